// File: rtl/system_top.sv
// system_top -- rate-1/2, K=3 (generators 111/101) hard-decision Viterbi
// decoder with a one-word-in / one-byte-out packet handshake.
//
// Each accepted 16-bit word carries 8 coded symbol pairs. It runs 8 ACS
// stages, picks the best state, then traces back 16 stages. The byte
// emitted is the oldest 8 bits of that walk, so packet k emits the decoded
// byte of packet k-1. Trellis metrics, survivors and the write pointer
// persist across packets.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   dvalid_i  input word valid; taken only while busy_o=0
//   data_i    coded word; [15-2i]=g0, [14-2i]=g1 of info bit i
//   busy_o    high while a packet is in flight
//   valid_o   one-cycle pulse, data_o holds a new byte
//   data_o    decoded byte, bit i = info bit i; held between pulses
//
// Optional build macro WARMUP_SUPPRESS_EN: the first packet after reset
// issues no valid_o instead of emitting the 0x00 warmup byte.

module acs_lane #(
  parameter int          METRIC_W = 8,
  parameter logic [1:0]  DST      = 2'd0
) (
  input  logic [METRIC_W-1:0] pm_a,   // metric of predecessor {DST[0],0}
  input  logic [METRIC_W-1:0] pm_b,   // metric of predecessor {DST[0],1}
  input  logic [1:0]          sym,    // {g0,g1} received
  output logic [METRIC_W-1:0] pm_new,
  output logic                dec     // 1: predecessor {DST[0],1} survives
);
  logic [1:0]          bm_a, bm_b;
  logic [METRIC_W:0]   sum_a, sum_b;
  logic [METRIC_W-1:0] cand_a, cand_b;

  always_comb begin
    // Branch from {d0,0}: g0 = d1^d0, g1 = d1. The {d0,1} branch emits the
    // complement pair, so its distance is 2 minus this one.
    bm_a   = {1'b0, sym[1] ^ DST[1] ^ DST[0]} + {1'b0, sym[0] ^ DST[1]};
    bm_b   = 2'd2 - bm_a;
    sum_a  = {1'b0, pm_a} + {{(METRIC_W-1){1'b0}}, bm_a};
    sum_b  = {1'b0, pm_b} + {{(METRIC_W-1){1'b0}}, bm_b};
    cand_a = sum_a[METRIC_W] ? '1 : sum_a[METRIC_W-1:0];
    cand_b = sum_b[METRIC_W] ? '1 : sum_b[METRIC_W-1:0];
    // strict compare: on a tie the lower-index predecessor wins
    dec    = (cand_b < cand_a);
    pm_new = dec ? cand_b : cand_a;
  end
endmodule

module system_top #(
  parameter int METRIC_W = 8,
  parameter int TB_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dvalid_i,
  input  logic [15:0] data_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [7:0]  data_o
);
  localparam int NS  = 4;
  localparam int TBW = $clog2(TB_DEPTH);

  typedef enum logic [2:0] {IDLE, ACS, BEST, TRACE, OUTPUT} st_t;
  st_t state, state_nx;

  logic [15:0]                 sym_sr;
  logic [2:0]                  stg;
  logic [TBW-1:0]              tb_cnt, wp, tb_ptr;
  logic [NS-1:0][METRIC_W-1:0] pm, pm_raw, pm_norm;
  logic [NS-1:0]               dec;
  logic [TB_DEPTH-1:0][NS-1:0] surv;
  logic [1:0]                  tb_st, best;
  logic [7:0]                  tb_byte;
  logic                        warm, accept;
  logic                        busy_nx, valid_nx;
  logic [7:0]                  data_nx;
  logic [METRIC_W-1:0]         pm_min, best_m;

  assign accept = (state == IDLE) && dvalid_i && !busy_o;

  for (genvar d = 0; d < NS; d++) begin : g_lane
    localparam logic [1:0] DST = 2'(d);
    acs_lane #(.METRIC_W(METRIC_W), .DST(DST)) u_acs (
      .pm_a  (pm[{DST[0], 1'b0}]),
      .pm_b  (pm[{DST[0], 1'b1}]),
      .sym   (sym_sr[15:14]),
      .pm_new(pm_raw[d]),
      .dec   (dec[d])
    );
  end

  // renormalise so the best new metric is zero; metrics stay small
  always_comb begin
    pm_min = pm_raw[0];
    for (int i = 1; i < NS; i++)
      if (pm_raw[i] < pm_min) pm_min = pm_raw[i];
    for (int i = 0; i < NS; i++)
      pm_norm[i] = pm_raw[i] - pm_min;
  end

  // lowest index wins a tie
  always_comb begin
    best   = 2'd0;
    best_m = pm[0];
    for (int i = 1; i < NS; i++)
      if (pm[i] < best_m) begin
        best_m = pm[i];
        best   = 2'(i);
      end
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACS;
      ACS:     if (stg == 3'd7) state_nx = BEST;
      BEST:    state_nx = TRACE;
      TRACE:   if (tb_cnt == TBW'(TB_DEPTH-1)) state_nx = OUTPUT;
      OUTPUT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs (registered below). busy_o stays high through the valid_o
  // cycle and drops one cycle later, so IDLE must also see busy_o low.
  always_comb begin
    busy_nx  = 1'b1;
    valid_nx = 1'b0;
    data_nx  = data_o;
    case (state)
      IDLE:   busy_nx = accept;
      OUTPUT: begin
`ifdef WARMUP_SUPPRESS_EN
        valid_nx = !warm;
        data_nx  = warm ? data_o : tb_byte;
`else
        valid_nx = 1'b1;
        data_nx  = warm ? 8'h00 : tb_byte;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= 8'h00;
    end else begin
      busy_o  <= busy_nx;
      valid_o <= valid_nx;
      data_o  <= data_nx;
    end

  // datapath
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sym_sr  <= '0;
      stg     <= '0;
      tb_cnt  <= '0;
      wp      <= '0;
      tb_ptr  <= '0;
      tb_st   <= '0;
      tb_byte <= '0;
      surv    <= '0;
      warm    <= 1'b1;
      for (int i = 0; i < NS; i++)
        pm[i] <= (i == 0) ? '0 : METRIC_W'(1) << (METRIC_W-2);
    end else begin
      case (state)
        IDLE: if (accept) begin
          sym_sr <= data_i;
          stg    <= '0;
        end
        ACS: begin
          pm       <= pm_norm;
          surv[wp] <= dec;
          wp       <= wp + TBW'(1);
          sym_sr   <= {sym_sr[13:0], 2'b00};
          stg      <= stg + 3'd1;
        end
        BEST: begin
          tb_st  <= best;
          tb_ptr <= wp - TBW'(1);
          tb_cnt <= '0;
        end
        TRACE: begin
          // decoded bit is the MSB of the state; step to {s0, decision}
          if (tb_cnt >= TBW'(TB_DEPTH/2))
            tb_byte <= {tb_byte[6:0], tb_st[1]};
          tb_st  <= {tb_st[0], surv[tb_ptr][tb_st]};
          tb_ptr <= tb_ptr - TBW'(1);
          tb_cnt <= tb_cnt + TBW'(1);
        end
        OUTPUT: warm <= 1'b0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_system_top.sv
module tb_system_top;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dvalid_i = 1'b0;
  logic [15:0] data_i = 16'h0;
  logic        busy_o, valid_o;
  logic [7:0]  data_o;

  int ntot = 0, npass = 0;
  int cyc = 0, vcount = 0;
  logic [1:0] enc_s = 2'b00;
  logic [7:0] prev = 8'h00;
  bit         warm = 1'b1;

  system_top dut (
    .clk(clk), .rst(rst), .dvalid_i(dvalid_i), .data_i(data_i),
    .busy_o(busy_o), .valid_o(valid_o), .data_o(data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid_o) vcount <= vcount + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // reference convolutional encoder, state carried across packets
  task automatic encode(input logic [7:0] b, output logic [15:0] w);
    logic bit_i;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      bit_i       = b[i];
      w[15-2*i]   = bit_i ^ enc_s[1] ^ enc_s[0];
      w[14-2*i]   = bit_i ^ enc_s[0];
      enc_s       = {bit_i, enc_s[1]};
    end
  endtask

  // send one byte (optionally one coded bit flipped, optionally a dvalid
  // pulse while busy) and check the byte that comes back
  task automatic pkt(input logic [7:0] b, input int flip, input bit poke);
    logic [15:0] w;
    logic [7:0]  expb;
    int t, acc;
    bit got;
    bit supp;
    encode(b, w);
    if (flip >= 0) w = w ^ (16'd1 << flip);
    t = 0;
    while (busy_o && t < 100) begin @(negedge clk); t++; end
    chk("idle_wait", int'(busy_o), 0);
    dvalid_i = 1'b1; data_i = w;
    @(negedge clk);
    dvalid_i = 1'b0; data_i = 16'h0; acc = cyc;
    chk("busy_rise", int'(busy_o), 1);
    got = 0; t = 0;
    while (!got && t < 60) begin
      @(negedge clk); t++;
      if (poke) begin dvalid_i = (t == 5); data_i = (t == 5) ? 16'hFFFF : 16'h0; end
      if (valid_o) got = 1;
    end
    dvalid_i = 1'b0;
    expb = warm ? 8'h00 : prev;
    supp = 0;
`ifdef WARMUP_SUPPRESS_EN
    supp = warm;
`endif
    if (supp) begin
      chk("warm_suppressed", int'(got), 0);
      chk("busy_after_supp", int'(busy_o), 0);
    end else begin
      chk("valid_seen", int'(got), 1);
      if (got) begin
        chk("latency", cyc - acc, 26);
        chk("data", int'(data_o), int'(expb));
        chk("busy_at_valid", int'(busy_o), 1);
        @(negedge clk);
        chk("valid_pulse", int'(valid_o), 0);
        chk("busy_fall", int'(busy_o), 0);
        chk("data_hold", int'(data_o), int'(expb));
      end
    end
    warm = 0;
    prev = b;
  endtask

  initial begin
    int v0;
    logic [7:0] pat [4] = '{8'h00, 8'hFF, 8'hAA, 8'h55};
    logic [15:0] w;
    repeat (10) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_no_valid", vcount, 0);
    chk("idle_busy", int'(busy_o), 0);

    // directed patterns, then zero flush
    for (int i = 0; i < 4; i++) pkt(pat[i], -1, 0);
    for (int i = 0; i < 20; i++) pkt(8'h00, -1, 0);

    // one flipped coded bit per packet
    for (int i = 0; i < 20; i++) pkt(8'($urandom_range(255, 0)), int'($urandom_range(15, 0)), 0);
    for (int i = 0; i < 20; i++) pkt(8'h00, -1, 0);

    // back-to-back, one packet gets a dvalid pulse while busy
    v0 = vcount;
    for (int i = 0; i < 20; i++) pkt(8'(i), -1, (i == 7));
    pkt(8'h00, -1, 0);
    @(negedge clk);
    chk("b2b_count", vcount - v0, 21);

    // abort mid-packet with reset
    encode(8'hAA, w);
    dvalid_i = 1'b1; data_i = w;
    @(negedge clk);
    dvalid_i = 1'b0; data_i = 16'h0;
    repeat (10) @(negedge clk);
    chk("busy_mid", int'(busy_o), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_valid", int'(valid_o), 0);
    chk("abort_data", int'(data_o), 0);
    @(negedge clk);
    rst = 1'b0;
    v0 = vcount;
    repeat (40) @(negedge clk);
    chk("abort_no_valid", vcount - v0, 0);
    enc_s = 2'b00; warm = 1; prev = 8'h00;
    for (int i = 0; i < 10; i++) pkt(8'(i * 17), -1, 0);
    for (int i = 0; i < 4; i++) pkt(8'h00, -1, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
